// File: rtl/snitch_icache_lookup_arbiter_if.sv
// Handshake bundle between the L0/prefetch requesters, the shared lookup stage and the
// lookup arbiter; the arbiter takes the slave view, the surrounding fabric the master view.
interface snitch_icache_lookup_arbiter_if #(
   parameter int NR_PORTS = 2,
   parameter int FETCH_AW = 32,
   parameter int ID_WIDTH = 4
);
   localparam int PW = $clog2(NR_PORTS);

   logic [NR_PORTS*FETCH_AW-1:0] req_addr_i;
   logic [NR_PORTS*ID_WIDTH-1:0] req_id_i;
   logic [NR_PORTS-1:0]          req_valid_i;
   logic [NR_PORTS-1:0]          req_ready_o;
   logic [NR_PORTS-1:0]          flush_req_i;
   logic [NR_PORTS-1:0]          flush_ack_o;
   logic [FETCH_AW-1:0]          lookup_addr_o;
   logic [ID_WIDTH+PW-1:0]       lookup_id_o;
   logic                         lookup_valid_o;
   logic                         lookup_ready_i;
   logic                         lookup_flush_valid_o;
   logic                         lookup_flush_ready_i;
   logic [ID_WIDTH+PW-1:0]       rsp_id_i;
   logic                         rsp_valid_i;
   logic                         rsp_ready_i;
   logic [NR_PORTS-1:0]          rsp_port_o;
   logic [ID_WIDTH-1:0]          rsp_id_o;
   logic                         busy_o;

   modport slave (
      input  req_addr_i, req_id_i, req_valid_i, flush_req_i, lookup_ready_i,
             lookup_flush_ready_i, rsp_id_i, rsp_valid_i, rsp_ready_i,
      output req_ready_o, flush_ack_o, lookup_addr_o, lookup_id_o, lookup_valid_o,
             lookup_flush_valid_o, rsp_port_o, rsp_id_o, busy_o
   );

   modport master (
      output req_addr_i, req_id_i, req_valid_i, flush_req_i, lookup_ready_i,
             lookup_flush_ready_i, rsp_id_i, rsp_valid_i, rsp_ready_i,
      input  req_ready_o, flush_ack_o, lookup_addr_o, lookup_id_o, lookup_valid_o,
             lookup_flush_valid_o, rsp_port_o, rsp_id_o, busy_o
   );
endinterface

// File: rtl/snitch_icache_lookup_arbiter.sv
// Round-robin arbiter sharing one serial icache lookup between NR_PORTS requesters, with a
// locked grant, an in-flight cap and a block/drain/flush/acknowledge flush sequencer.
module snitch_icache_lookup_arbiter #(
   parameter int NR_PORTS        = 2,
   parameter int FETCH_AW        = 32,
   parameter int ID_WIDTH        = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input logic                           clk_i,
   input logic                           rst_i,
   snitch_icache_lookup_arbiter_if.slave bus
);
   localparam int PW = $clog2(NR_PORTS);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [1:0] ARB   = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;
   localparam logic [1:0] ACK   = 2'd3;

   logic [1:0]          state, state_nxt;
   logic [PW-1:0]       rr_ptr, lock_idx, cand_idx, winner;
   logic [PW:0]         scan;
   logic                locked, cand_found, flush_start, grant, lookup_hs, rsp_hs;
   logic [CW-1:0]       outstanding, outstanding_nxt;
   logic [NR_PORTS-1:0] flush_mask;
   logic [ID_WIDTH-1:0] sel_id;

   // Scan from the rr pointer downwards in reverse so the first valid port in cyclic order wins.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      scan       = '0;
      for (int i = NR_PORTS - 1; i >= 0; i--) begin
         scan = {1'b0, rr_ptr} + (PW+1)'(i);
         if (scan >= (PW+1)'(NR_PORTS)) scan = scan - (PW+1)'(NR_PORTS);
         if (bus.req_valid_i[scan[PW-1:0]]) begin
            cand_found = 1'b1;
            cand_idx   = scan[PW-1:0];
         end
      end
   end

   // A locked port is served before any pending flush may start.
   always_comb begin
      flush_start = (state == ARB) && !locked && (|bus.flush_req_i);
      winner      = locked ? lock_idx : cand_idx;
      grant       = !rst_i && (state == ARB) &&
                    (locked || (cand_found && !flush_start &&
                                (outstanding < CW'(MAX_OUTSTANDING))));
      lookup_hs   = grant && bus.lookup_ready_i;
      rsp_hs      = bus.rsp_valid_i && bus.rsp_ready_i;
   end

   always_comb begin
      bus.lookup_addr_o = '0;
      sel_id            = '0;
      for (int p = 0; p < NR_PORTS; p++) begin
         if (winner == PW'(p)) begin
            bus.lookup_addr_o = bus.req_addr_i[p*FETCH_AW +: FETCH_AW];
            sel_id            = bus.req_id_i[p*ID_WIDTH +: ID_WIDTH];
         end
      end
   end

   always_comb begin
      bus.req_ready_o = '0;
      bus.rsp_port_o  = '0;
      if (lookup_hs) bus.req_ready_o[winner] = 1'b1;
      if (bus.rsp_valid_i) bus.rsp_port_o[bus.rsp_id_i[ID_WIDTH +: PW]] = 1'b1;
   end

   always_comb begin
      outstanding_nxt = outstanding;
      if (lookup_hs && !rsp_hs)
         outstanding_nxt = outstanding + 1'b1;
      else if (rsp_hs && !lookup_hs && (outstanding != '0))
         outstanding_nxt = outstanding - 1'b1;

      // DRAIN looks at the next count so a final response moves straight on to FLUSH.
      state_nxt = state;
      case (state)
         ARB:     if (flush_start) state_nxt = DRAIN;
         DRAIN:   if (outstanding_nxt == '0) state_nxt = FLUSH;
         FLUSH:   if (bus.lookup_flush_ready_i) state_nxt = ACK;
         default: state_nxt = ARB;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ARB;
         rr_ptr      <= '0;
         outstanding <= '0;
         locked      <= 1'b0;
         lock_idx    <= '0;
         flush_mask  <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         locked      <= grant && !bus.lookup_ready_i;
         if (grant) lock_idx <= winner;
         if (lookup_hs) rr_ptr <= (winner == PW'(NR_PORTS - 1)) ? '0 : winner + 1'b1;
         if (flush_start) flush_mask <= bus.flush_req_i;
         else if (state == ACK) flush_mask <= '0;
      end
   end

   assign bus.lookup_valid_o       = grant;
   assign bus.lookup_id_o          = {winner, sel_id};
   assign bus.lookup_flush_valid_o = (state == FLUSH);
   assign bus.flush_ack_o          = (state == ACK) ? flush_mask : '0;
   assign bus.rsp_id_o             = bus.rsp_id_i[ID_WIDTH-1:0];
   assign bus.busy_o               = (state != ARB) || (outstanding != '0);

   a_lock_held: assert property (@(posedge clk_i) disable iff (rst_i)
      locked |-> bus.req_valid_i[lock_idx]);
   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(rsp_hs && !lookup_hs && (outstanding == '0)));
endmodule

// File: tb/tb_snitch_icache_lookup_arbiter.sv
// Bench for snitch_icache_lookup_arbiter: cycle table, hand sequences for cap/flush/lock/reset,
// then random traffic against a queue-based reference model.
module tb_snitch_icache_lookup_arbiter;
   localparam int NP = 2;
   localparam int AW = 32;
   localparam int IW = 4;
   localparam int MO = 4;
   localparam int PW = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   snitch_icache_lookup_arbiter_if #(.NR_PORTS(NP), .FETCH_AW(AW), .ID_WIDTH(IW)) bus ();

   snitch_icache_lookup_arbiter #(
      .NR_PORTS(NP), .FETCH_AW(AW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [1:0]  rv;
      logic        lr;
      logic        rsv;
      logic        rsidx;
      logic [1:0]  e_rdy;
      logic        e_lv;
      logic [31:0] e_addr;
      logic [4:0]  e_id;
      logic        e_busy;
      logic [1:0]  e_rport;
   } vec_t;
   vec_t tbl [10];

   // random-phase model state
   int          q[$];
   int          rr;
   logic        held_on;
   logic [0:0]  held_p;
   logic [31:0] h_addr;
   logic [3:0]  h_id;
   logic [1:0]  r_rv;
   logic [31:0] r_addr [NP];
   logic [3:0]  r_id [NP];
   logic        exp_on;
   logic [0:0]  exp_p;
   logic [1:0]  exp_rdy, exp_rport;
   int          n;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      bus.req_addr_i           = {32'h0000_0200, 32'h0000_0100};
      bus.req_id_i             = {4'h5, 4'h3};
      bus.req_valid_i          = '0;
      bus.flush_req_i          = '0;
      bus.lookup_ready_i       = 1'b0;
      bus.lookup_flush_ready_i = 1'b0;
      bus.rsp_id_i             = 5'h0A;
      bus.rsp_valid_i          = 1'b0;
      bus.rsp_ready_i          = 1'b0;
   endtask

   task automatic rsp(input logic on, input logic idx);
      bus.rsp_valid_i = on;
      bus.rsp_ready_i = on;
      bus.rsp_id_i    = {idx, 4'hA};
   endtask

   task automatic run_count(input int cycles, output int hs);
      hs = 0;
      for (int c = 0; c < cycles; c++) begin
         settle();
         if (bus.lookup_valid_o && bus.lookup_ready_i) hs++;
         tick();
      end
   endtask

   task automatic drain(input int k);
      bus.req_valid_i = '0;
      rsp(1'b1, 1'b0);
      for (int c = 0; c < k; c++) tick();
      rsp(1'b0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      //            rv     lr    rsv   idx   e_rdy  e_lv  e_addr        e_id   busy  rport
      tbl[0] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        5'h00, 1'b0, 2'b00};
      tbl[1] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0100, 5'h03, 1'b0, 2'b00};
      tbl[2] = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0100, 5'h03, 1'b0, 2'b00};
      tbl[3] = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0100, 5'h03, 1'b0, 2'b00};
      tbl[4] = '{2'b11, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 32'h0000_0100, 5'h03, 1'b0, 2'b00};
      tbl[5] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0200, 5'h15, 1'b1, 2'b01};
      tbl[6] = '{2'b11, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 32'h0000_0100, 5'h03, 1'b1, 2'b10};
      tbl[7] = '{2'b11, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0200, 5'h15, 1'b1, 2'b01};
      tbl[8] = '{2'b00, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0,        5'h00, 1'b1, 2'b10};
      tbl[9] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0,        5'h00, 1'b0, 2'b00};

      idle();
      tick();
      settle();
      chk("rst lookup_valid", 64'(bus.lookup_valid_o), 64'(1'b0));
      chk("rst flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b0));
      chk("rst flush_ack", 64'(bus.flush_ack_o), 64'(2'b00));
      chk("rst busy", 64'(bus.busy_o), 64'(1'b0));
      chk("rst req_ready", 64'(bus.req_ready_o), 64'(2'b00));
      tick();
      rst = 1'b0;

      // round robin and lock, one row per cycle
      for (int i = 0; i < 10; i++) begin
         bus.req_valid_i    = tbl[i].rv;
         bus.lookup_ready_i = tbl[i].lr;
         rsp(tbl[i].rsv, tbl[i].rsidx);
         settle();
         chk($sformatf("tbl%0d req_ready", i), 64'(bus.req_ready_o), 64'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d lookup_valid", i), 64'(bus.lookup_valid_o), 64'(tbl[i].e_lv));
         chk($sformatf("tbl%0d busy", i), 64'(bus.busy_o), 64'(tbl[i].e_busy));
         chk($sformatf("tbl%0d rsp_port", i), 64'(bus.rsp_port_o), 64'(tbl[i].e_rport));
         chk($sformatf("tbl%0d rsp_id", i), 64'(bus.rsp_id_o), 64'(4'hA));
         if (tbl[i].e_lv) begin
            chk($sformatf("tbl%0d addr", i), 64'(bus.lookup_addr_o), 64'(tbl[i].e_addr));
            chk($sformatf("tbl%0d id", i), 64'(bus.lookup_id_o), 64'(tbl[i].e_id));
         end
         tick();
      end
      idle();

      // outstanding cap
      bus.req_valid_i    = 2'b11;
      bus.lookup_ready_i = 1'b1;
      run_count(6, n);
      chk("cap handshakes", 64'(n), 64'(4));
      rsp(1'b1, 1'b0);
      settle();
      chk("cap lookup_valid", 64'(bus.lookup_valid_o), 64'(1'b0));
      chk("cap busy", 64'(bus.busy_o), 64'(1'b1));
      tick();
      rsp(1'b0, 1'b0);
      run_count(4, n);
      chk("cap refill", 64'(n), 64'(1));
      drain(4);
      settle();
      chk("cap drained busy", 64'(bus.busy_o), 64'(1'b0));
      tick();

      // simultaneous lookup and response handshakes at count 2
      bus.req_valid_i    = 2'b11;
      bus.lookup_ready_i = 1'b1;
      run_count(2, n);
      chk("simul prefill", 64'(n), 64'(2));
      rsp(1'b1, 1'b1);
      settle();
      chk("simul both hs", 64'(bus.lookup_valid_o), 64'(1'b1));
      tick();
      rsp(1'b0, 1'b0);
      run_count(5, n);
      chk("simul remaining room", 64'(n), 64'(2));
      drain(4);
      tick();

      // flush drain with two lookups in flight
      bus.req_valid_i    = 2'b11;
      bus.lookup_ready_i = 1'b1;
      run_count(2, n);
      bus.req_valid_i = 2'b01;
      bus.flush_req_i = 2'b10;
      settle();
      chk("flush start lookup_valid", 64'(bus.lookup_valid_o), 64'(1'b0));
      chk("flush start req_ready", 64'(bus.req_ready_o), 64'(2'b00));
      tick();
      rsp(1'b1, 1'b0);
      settle();
      chk("drain t lookup_valid", 64'(bus.lookup_valid_o), 64'(1'b0));
      chk("drain t flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b0));
      tick();
      rsp(1'b0, 1'b0);
      for (int k = 1; k <= 2; k++) begin
         settle();
         chk($sformatf("drain t+%0d flush_valid", k), 64'(bus.lookup_flush_valid_o), 64'(1'b0));
         chk($sformatf("drain t+%0d lookup_valid", k), 64'(bus.lookup_valid_o), 64'(1'b0));
         tick();
      end
      rsp(1'b1, 1'b1);
      settle();
      chk("drain t+3 flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b0));
      tick();
      rsp(1'b0, 1'b0);
      settle();
      chk("flush t+4 flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b1));
      chk("flush t+4 busy", 64'(bus.busy_o), 64'(1'b1));
      tick();
      bus.lookup_flush_ready_i = 1'b1;
      settle();
      chk("flush t+5 flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b1));
      chk("flush t+5 ack", 64'(bus.flush_ack_o), 64'(2'b00));
      tick();
      bus.lookup_flush_ready_i = 1'b0;
      settle();
      chk("flush t+6 ack", 64'(bus.flush_ack_o), 64'(2'b10));
      chk("flush t+6 flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b0));
      tick();
      bus.flush_req_i = 2'b00;
      bus.req_valid_i = 2'b00;
      settle();
      chk("flush t+7 ack", 64'(bus.flush_ack_o), 64'(2'b00));
      chk("flush t+7 busy", 64'(bus.busy_o), 64'(1'b0));
      tick();

      // flush raised while a grant is locked
      bus.req_valid_i    = 2'b01;
      bus.lookup_ready_i = 1'b0;
      settle();
      chk("lockflush lookup_valid", 64'(bus.lookup_valid_o), 64'(1'b1));
      tick();
      bus.flush_req_i = 2'b01;
      settle();
      chk("lockflush held valid", 64'(bus.lookup_valid_o), 64'(1'b1));
      chk("lockflush held addr", 64'(bus.lookup_addr_o), 64'(32'h0000_0100));
      chk("lockflush no flush", 64'(bus.lookup_flush_valid_o), 64'(1'b0));
      tick();
      bus.lookup_ready_i = 1'b1;
      settle();
      chk("lockflush accept", 64'(bus.req_ready_o), 64'(2'b01));
      tick();
      settle();
      chk("lockflush then block", 64'(bus.lookup_valid_o), 64'(1'b0));
      tick();
      bus.req_valid_i = 2'b00;
      rsp(1'b1, 1'b0);
      settle();
      chk("lockflush drain", 64'(bus.lookup_flush_valid_o), 64'(1'b0));
      tick();
      rsp(1'b0, 1'b0);
      bus.lookup_flush_ready_i = 1'b1;
      settle();
      chk("lockflush flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b1));
      tick();
      bus.lookup_flush_ready_i = 1'b0;
      settle();
      chk("lockflush ack", 64'(bus.flush_ack_o), 64'(2'b01));
      tick();
      bus.flush_req_i = 2'b00;
      settle();
      chk("lockflush after ack", 64'(bus.flush_ack_o), 64'(2'b00));
      chk("lockflush idle busy", 64'(bus.busy_o), 64'(1'b0));
      tick();

      // asynchronous reset while the flush is pending at the lookup
      bus.flush_req_i = 2'b10;
      tick();
      settle();
      chk("rstflush drain", 64'(bus.lookup_flush_valid_o), 64'(1'b0));
      tick();
      settle();
      chk("rstflush flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b1));
      #2;
      rst = 1'b1;
      #1;
      chk("rstflush async flush_valid", 64'(bus.lookup_flush_valid_o), 64'(1'b0));
      chk("rstflush async busy", 64'(bus.busy_o), 64'(1'b0));
      bus.flush_req_i = 2'b00;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("rstflush post%0d ack", k), 64'(bus.flush_ack_o), 64'(2'b00));
         chk($sformatf("rstflush post%0d busy", k), 64'(bus.busy_o), 64'(1'b0));
         chk($sformatf("rstflush post%0d flush_valid", k), 64'(bus.lookup_flush_valid_o), 64'(1'b0));
         tick();
      end

      // random traffic against the in-flight queue model (pointer at 0 after reset)
      rr      = 0;
      held_on = 1'b0;
      held_p  = '0;
      h_addr  = '0;
      h_id    = '0;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            r_rv[PW'(p)] = ($urandom_range(0, 3) != 0);
            r_addr[p]    = $urandom();
            r_id[p]      = 4'($urandom());
         end
         if (held_on) begin
            r_rv[held_p]   = 1'b1;
            r_addr[held_p] = h_addr;
            r_id[held_p]   = h_id;
         end
         bus.req_valid_i    = r_rv;
         bus.req_addr_i     = {r_addr[1], r_addr[0]};
         bus.req_id_i       = {r_id[1], r_id[0]};
         bus.lookup_ready_i = ($urandom_range(0, 2) != 0);
         bus.rsp_valid_i    = (q.size() != 0) && ($urandom_range(0, 1) == 1);
         bus.rsp_ready_i    = ($urandom_range(0, 3) != 0);
         if (bus.rsp_valid_i) bus.rsp_id_i = 5'(q[0]);
         else bus.rsp_id_i = 5'($urandom());

         exp_on = 1'b0;
         exp_p  = '0;
         if (held_on) begin
            exp_on = 1'b1;
            exp_p  = held_p;
         end else if (q.size() < MO) begin
            for (int k = 0; k < NP; k++) begin
               if (!exp_on && r_rv[PW'((rr + k) % NP)]) begin
                  exp_on = 1'b1;
                  exp_p  = PW'((rr + k) % NP);
               end
            end
         end
         exp_rdy   = (exp_on && bus.lookup_ready_i) ? (2'b01 << exp_p) : 2'b00;
         exp_rport = bus.rsp_valid_i ? 2'(1 << (q[0] >> IW)) : 2'b00;

         settle();
         chk($sformatf("rnd%0d lookup_valid", c), 64'(bus.lookup_valid_o), 64'(exp_on));
         chk($sformatf("rnd%0d req_ready", c), 64'(bus.req_ready_o), 64'(exp_rdy));
         chk($sformatf("rnd%0d rsp_port", c), 64'(bus.rsp_port_o), 64'(exp_rport));
         chk($sformatf("rnd%0d rsp_id", c), 64'(bus.rsp_id_o), 64'(bus.rsp_id_i[3:0]));
         chk($sformatf("rnd%0d busy", c), 64'(bus.busy_o), 64'(q.size() != 0));
         if (exp_on) begin
            chk($sformatf("rnd%0d addr", c), 64'(bus.lookup_addr_o), 64'(r_addr[exp_p]));
            chk($sformatf("rnd%0d id", c), 64'(bus.lookup_id_o), 64'({exp_p, r_id[exp_p]}));
         end

         if (bus.rsp_valid_i && bus.rsp_ready_i) void'(q.pop_front());
         if (exp_on) begin
            if (bus.lookup_ready_i) begin
               q.push_back(int'({exp_p, r_id[exp_p]}));
               rr      = (int'(exp_p) + 1) % NP;
               held_on = 1'b0;
            end else begin
               held_on = 1'b1;
               held_p  = exp_p;
               h_addr  = r_addr[exp_p];
               h_id    = r_id[exp_p];
            end
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
